// File: rtl/program_loader.sv
// Boot loader: packs a little-endian byte stream into instruction words.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_DEPTH  = 32,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start_i,
  input  logic [ADDRESS_WIDTH-1:0] Length_i,
  input  logic [7:0]               Byte_i,
  input  logic                     Byte_Valid_i,
  output logic                     Byte_Ready_o,
  output logic                     Mem_Write_o,
  output logic [DATA_WIDTH-1:0]    Mem_Address_o,
  output logic [DATA_WIDTH-1:0]    Mem_Data_o,
  output logic                     Core_Hold_o,
  output logic                     Busy_o,
  output logic                     Done_o,
  output logic                     Error_o
);

  localparam int PADW = DATA_WIDTH - ADDRESS_WIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [ADDRESS_WIDTH-1:0] r_len;
  logic [ADDRESS_WIDTH-1:0] r_word_cnt;
  logic [1:0]              r_byte_cnt;
  logic [DATA_WIDTH-9:0]   r_asm;
  logic                    r_ready;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_hold;
  logic                    r_done;
  logic                    r_error;

  logic w_xfer;
  logic w_len_ok;
  logic w_last;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;
  assign w_sum_next = r_sum + Byte_i;
`endif

  assign w_xfer   = Byte_Valid_i & r_ready;
  assign w_len_ok = (Length_i != '0) &&
                    (Length_i <= ADDRESS_WIDTH'(MEMORY_DEPTH));
  assign w_last   = (r_word_cnt + ADDRESS_WIDTH'(1)) == r_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_ready    <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start_i) begin
            if (w_len_ok) begin
              r_state    <= S_RECV;
              r_len      <= Length_i;
              r_word_cnt <= '0;
              r_byte_cnt <= '0;
              r_asm      <= '0;
              r_error    <= 1'b0;
              r_hold     <= 1'b1;
              r_ready    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              r_sum      <= '0;
`endif
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= w_sum_next;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_write <= 1'b1;
              r_addr  <= {{PADW{1'b0}}, r_word_cnt, 2'b00};
              r_data  <= {Byte_i, r_asm};
            end else begin
              r_asm[8*r_byte_cnt +: 8] <= Byte_i;
            end
          end
        end
        S_WRITE: begin
          r_word_cnt <= r_word_cnt + ADDRESS_WIDTH'(1);
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CHECK;
            r_ready <= 1'b1;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
`endif
          end else begin
            r_state <= S_RECV;
            r_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        // failed checksum keeps the core held until a new load
        S_CHECK: begin
          if (w_xfer) begin
            r_ready <= 1'b0;
            if (w_sum_next == 8'h00) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Byte_Ready_o  = r_ready;
  assign Mem_Write_o   = r_write;
  assign Mem_Address_o = r_addr;
  assign Mem_Data_o    = r_data;
  assign Core_Hold_o   = r_hold;
  assign Busy_o        = (r_state != S_IDLE);
  assign Done_o        = r_done;
  assign Error_o       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Strobes and done pulses are captured on the falling edge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start_i = 1'b0;
  logic [5:0]  Length_i = '0;
  logic [7:0]  Byte_i = '0;
  logic        Byte_Valid_i = 1'b0;
  logic        Byte_Ready_o;
  logic        Mem_Write_o;
  logic [31:0] Mem_Address_o;
  logic [31:0] Mem_Data_o;
  logic        Core_Hold_o;
  logic        Busy_o;
  logic        Done_o;
  logic        Error_o;

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .Start_i      (Start_i),
    .Length_i     (Length_i),
    .Byte_i       (Byte_i),
    .Byte_Valid_i (Byte_Valid_i),
    .Byte_Ready_o (Byte_Ready_o),
    .Mem_Write_o  (Mem_Write_o),
    .Mem_Address_o(Mem_Address_o),
    .Mem_Data_o   (Mem_Data_o),
    .Core_Hold_o  (Core_Hold_o),
    .Busy_o       (Busy_o),
    .Done_o       (Done_o),
    .Error_o      (Error_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          n_done = 0;
  int          n_hold_done = 0;

  always @(negedge clk) begin
    if (Mem_Write_o) begin
      wa.push_back(Mem_Address_o);
      wd.push_back(Mem_Data_o);
    end
    if (Done_o) begin
      n_done++;
      if (Core_Hold_o) n_hold_done++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    wa.delete();
    wd.delete();
    n_done = 0;
    n_hold_done = 0;
  endtask

  task automatic start(input logic [5:0] len);
    @(negedge clk);
    Start_i  = 1'b1;
    Length_i = len;
    @(negedge clk);
    Start_i  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    Byte_i       = b;
    Byte_Valid_i = 1'b1;
    n = 0;
    while (!Byte_Ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_to", 32'(n), 32'(0));
    @(negedge clk);
    Byte_Valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_to", 32'(n < 200), 32'd1);
  endtask

  logic [7:0]  t2_b[12];
  int          t2_g[12];
  logic [31:0] t2_w[3];
  int          seq_bad;
  logic [31:0] ew;

  initial begin
    t2_b = '{8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'hA0, 8'h00,
             8'hB3, 8'h81, 8'h20, 8'h00};
    t2_g = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 0, 1, 0};
    t2_w = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};

    #3 reset = 1'b0;
    #1;
    chk("rst_busy", 32'(Busy_o), 0);
    chk("rst_hold", 32'(Core_Hold_o), 0);
    chk("rst_ready", 32'(Byte_Ready_o), 0);
    chk("rst_wr", 32'(Mem_Write_o), 0);
    chk("rst_addr", Mem_Address_o, 0);
    chk("rst_data", Mem_Data_o, 0);
    chk("rst_done", 32'(Done_o), 0);
    chk("rst_err", 32'(Error_o), 0);
    @(negedge clk);
    reset = 1'b1;

    // T1
    clr_mon();
    start(6'd1);
    chk("t1_busy", 32'(Busy_o), 1);
    chk("t1_hold", 32'(Core_Hold_o), 1);
    chk("t1_ready", 32'(Byte_Ready_o), 1);
    send_word(32'h0000_0013);
    chk("t1_lat", 32'(Mem_Write_o), 1);
    chk("t1_rdy_wr", 32'(Byte_Ready_o), 0);
    wait_idle();
    chk("t1_nwr", 32'(wa.size()), 1);
    chk("t1_addr", wa[0], 32'h0);
    chk("t1_data", wd[0], 32'h0000_0013);
    chk("t1_ndone", 32'(n_done), 1);
    chk("t1_hold_dn", 32'(n_hold_done), 0);
    chk("t1_hold_end", 32'(Core_Hold_o), 0);

    // T2
    clr_mon();
    start(6'd3);
    for (int i = 0; i < 12; i++) send_byte(t2_b[i], t2_g[i]);
    wait_idle();
    chk("t2_nwr", 32'(wa.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_addr%0d", i), wa[i], 32'(4 * i));
      chk($sformatf("t2_data%0d", i), wd[i], t2_w[i]);
    end
    chk("t2_ndone", 32'(n_done), 1);

    // T3
    clr_mon();
    start(6'd0);
    chk("t3_err0", 32'(Error_o), 1);
    chk("t3_busy0", 32'(Busy_o), 0);
    start(6'd33);
    chk("t3_err33", 32'(Error_o), 1);
    chk("t3_busy33", 32'(Busy_o), 0);
    chk("t3_hold", 32'(Core_Hold_o), 0);
    chk("t3_nwr", 32'(wa.size()), 0);
    start(6'd1);
    chk("t3_clr", 32'(Error_o), 0);
    chk("t3_busy", 32'(Busy_o), 1);
    send_word(32'hDEAD_BEEF);
    wait_idle();
    chk("t3_data", wd[0], 32'hDEAD_BEEF);

    // T4
    clr_mon();
    start(6'd2);
    send_word(32'h1122_3344);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #2 reset = 1'b0;
    #1;
    chk("t4_busy", 32'(Busy_o), 0);
    chk("t4_hold", 32'(Core_Hold_o), 0);
    chk("t4_ready", 32'(Byte_Ready_o), 0);
    chk("t4_data", Mem_Data_o, 0);
    chk("t4_err", 32'(Error_o), 0);
    @(negedge clk);
    reset = 1'b1;
    clr_mon();
    start(6'd2);
    send_word(32'hA1B2_C3D4);
    send_word(32'h0102_0304);
    wait_idle();
    chk("t4_nwr", 32'(wa.size()), 2);
    chk("t4_a0", wa[0], 32'h0);
    chk("t4_d0", wd[0], 32'hA1B2_C3D4);
    chk("t4_a1", wa[1], 32'h4);
    chk("t4_d1", wd[1], 32'h0102_0304);

    // T5
    clr_mon();
    start(6'd32);
    for (int k = 0; k < 128; k++) begin
      Start_i  = (k >= 1 && k < 11) ? k[0] : 1'b0;
      Length_i = 6'd1;
      case (k % 4)
        0: send_byte(8'(k / 4), 0);
        1: send_byte(8'(k / 4 + 1), 0);
        2: send_byte(8'hA5, 0);
        default: send_byte(8'h5A, 0);
      endcase
    end
    Start_i = 1'b0;
    wait_idle();
    chk("t5_nwr", 32'(wa.size()), 32);
    seq_bad = 0;
    for (int i = 0; i < 32 && i < wa.size(); i++) begin
      ew = {8'h5A, 8'hA5, 8'(i + 1), 8'(i)};
      if (wa[i] !== 32'(4 * i) || wd[i] !== ew) seq_bad++;
    end
    chk("t5_seq", 32'(seq_bad), 0);
    chk("t5_last", wa[31], 32'h7C);
    chk("t5_ndone", 32'(n_done), 1);
    chk("t5_hold", 32'(Core_Hold_o), 0);

`ifdef LOADER_CHECKSUM_EN
    // T6
    clr_mon();
    start(6'd1);
    send_word(32'h0000_0013);
    send_byte(8'hED, 0);
    wait_idle();
    chk("t6_done", 32'(n_done), 1);
    chk("t6_err", 32'(Error_o), 0);
    chk("t6_hold", 32'(Core_Hold_o), 0);
    clr_mon();
    start(6'd1);
    send_word(32'h0000_0013);
    send_byte(8'h00, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("t6b_done", 32'(n_done), 0);
    chk("t6b_err", 32'(Error_o), 1);
    chk("t6b_hold", 32'(Core_Hold_o), 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
